// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one single-port video BRAM between ULA fetch, buffered CPU
//            mirror writes and the bulk loader.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic        ce_7mn,
  input  logic        ula_rd,
  input  logic [14:0] ula_addr,
  output logic [7:0]  ula_dout,
  output logic        ula_valid,
  input  logic        cpu_wr,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        cpu_full,
  output logic        cpu_ovf,
  input  logic        ldr_req,
  input  logic [14:0] ldr_addr,
  input  logic [7:0]  ldr_data,
  output logic        ldr_ack,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic          run_q;
  logic [1:0]    fetch_q, fetch_d;
  logic [14:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    ula_dout_q, ula_dout_d;
  logic          ula_valid_q, ula_valid_d;
  logic          ldr_ack_q, ldr_ack_d;
  logic          cpu_full_q, cpu_full_d;
  logic          cpu_ovf_q, cpu_ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic [14:0]   fifo_addr_q [FIFO_DEPTH];
  logic [7:0]    fifo_data_q [FIFO_DEPTH];

  logic ula_grant, ldr_urgent, cpu_grant, ldr_grant, push;

  always_comb begin
    ula_grant  = run_q & ce_7mn & ula_rd;
    ldr_urgent = ldr_req & (starve_q == LIMIT_C);
    cpu_grant  = run_q & ~ula_grant & ~ldr_urgent & (count_q != '0);
    ldr_grant  = run_q & ~ula_grant & ~cpu_grant & ldr_req;
    // A pop in this slot frees a place even when the FIFO is full.
    push       = cpu_wr & ((count_q != DEPTH_C) | cpu_grant);

    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (ula_grant) begin
      mem_addr_d = ula_addr;
    end else if (cpu_grant) begin
      mem_addr_d = fifo_addr_q[rd_ptr_q];
      mem_din_d  = fifo_data_q[rd_ptr_q];
    end else if (ldr_grant) begin
      mem_addr_d = ldr_addr;
      mem_din_d  = ldr_data;
    end
    mem_we_d  = cpu_grant | ldr_grant;
    ldr_ack_d = ldr_grant;

    wr_ptr_d = push      ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = cpu_grant ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !cpu_grant)      count_d = count_q + CW'(1);
    else if (!push && cpu_grant) count_d = count_q - CW'(1);
    cpu_full_d = (count_d == DEPTH_C);
    cpu_ovf_d  = cpu_ovf_q | (cpu_wr & ~push);

    starve_d = starve_q;
    if (!ldr_req || ldr_grant)               starve_d = '0;
    else if (cpu_grant && starve_q != LIMIT_C) starve_d = starve_q + SW'(1);

    // Address out at E0, BRAM read at E1, capture at E2.
    fetch_d     = {fetch_q[0], ula_grant};
    ula_valid_d = fetch_q[1];
    ula_dout_d  = fetch_q[1] ? mem_dout : ula_dout_q;
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      run_q       <= 1'b0;
      fetch_q     <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      ula_dout_q  <= '0;
      ula_valid_q <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_full_q  <= 1'b0;
      cpu_ovf_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
    end else begin
      run_q       <= 1'b1;
      fetch_q     <= fetch_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      ula_dout_q  <= ula_dout_d;
      ula_valid_q <= ula_valid_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_full_q  <= cpu_full_d;
      cpu_ovf_q   <= cpu_ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= cpu_addr;
      fifo_data_q[wr_ptr_q] <= cpu_data;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;
  assign ula_dout  = ula_dout_q;
  assign ula_valid = ula_valid_q;
  assign ldr_ack   = ldr_ack_q;
  assign cpu_full  = cpu_full_q;
  assign cpu_ovf   = cpu_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Randomised scoreboard bench for vram_arbiter with a BRAM model.
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;

  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    int          e;
    logic [14:0] a;
    logic [7:0]  d;
  } ev_t;

  logic        clk = 1'b0;
  logic        nRESET = 1'b1;
  logic        ce_7mn = 0, ula_rd = 0, cpu_wr = 0, ldr_req = 0;
  logic [14:0] ula_addr = '0, cpu_addr = '0, ldr_addr = '0;
  logic [7:0]  cpu_data = '0, ldr_data = '0;
  logic [7:0]  ula_dout, mem_din, mem_dout;
  logic        ula_valid, cpu_full, cpu_ovf, ldr_ack, mem_we;
  logic [14:0] mem_addr;

  vram_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_sys(clk), .nRESET(nRESET), .ce_7mn(ce_7mn), .ula_rd(ula_rd),
    .ula_addr(ula_addr), .ula_dout(ula_dout), .ula_valid(ula_valid),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_full(cpu_full), .cpu_ovf(cpu_ovf), .ldr_req(ldr_req),
    .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_ack(ldr_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Read-first synchronous BRAM.
  logic [7:0] vram [0:32767];
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_din;
    mem_dout <= vram[mem_addr];
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model state and scoreboard queues.
  logic [7:0] shadow [0:32767];
  ev_t  fq[$];
  ev_t  wq[$];
  ev_t  uq[$];
  int   aq[$];
  int   starve_m = 0;
  bit   run_m = 0, ovf_m = 0, exp_full = 0, exp_ovf = 0;
  int   vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  // Slot-level model: one grant per slot, ULA reads see every earlier-slot write.
  task automatic model_step(output bit lg);
    int  e;
    bit  ug, cg;
    ev_t ev;
    e  = edge_n + 1;
    lg = 0;
    cg = 0;
    ug = run_m && ce_7mn && ula_rd;
    if (ug) begin
      ev.e = e + 2; ev.a = ula_addr; ev.d = shadow[ula_addr];
      uq.push_back(ev);
    end else if (run_m && ldr_req && starve_m == STARVE_LIMIT) lg = 1;
    else if (run_m && fq.size() > 0) cg = 1;
    else if (run_m && ldr_req) lg = 1;
    if (cg) begin
      ev = fq.pop_front(); ev.e = e;
      wq.push_back(ev); shadow[ev.a] = ev.d;
    end
    if (lg) begin
      ev.e = e; ev.a = ldr_addr; ev.d = ldr_data;
      wq.push_back(ev); aq.push_back(e); shadow[ev.a] = ev.d;
    end
    if (cpu_wr) begin
      if (fq.size() < FIFO_DEPTH) begin
        ev.e = 0; ev.a = cpu_addr; ev.d = cpu_data;
        fq.push_back(ev);
      end else ovf_m = 1;
    end
    if (!ldr_req || lg) starve_m = 0;
    else if (cg && starve_m < STARVE_LIMIT) starve_m++;
    exp_full = (fq.size() == FIFO_DEPTH);
    exp_ovf  = ovf_m;
    run_m    = 1;
  endtask

  task automatic model_reset();
    fq.delete(); wq.delete(); uq.delete(); aq.delete();
    starve_m = 0; run_m = 0; ovf_m = 0; exp_full = 0; exp_ovf = 0;
  endtask

  task automatic set_in(input bit ce, input bit rd, input logic [14:0] ua,
                        input bit wr, input logic [14:0] ca, input logic [7:0] cd,
                        input bit lr, input logic [14:0] la, input logic [7:0] ld);
    ce_7mn = ce; ula_rd = rd; ula_addr = ua;
    cpu_wr = wr; cpu_addr = ca; cpu_data = cd;
    ldr_req = lr; ldr_addr = la; ldr_data = ld;
  endtask

  task automatic slot(input bit ce, input bit rd, input logic [14:0] ua,
                      input bit wr, input logic [14:0] ca, input logic [7:0] cd,
                      input bit lr, input logic [14:0] la, input logic [7:0] ld,
                      output bit lg);
    @(negedge clk);
    set_in(ce, rd, ua, wr, ca, cd, lr, la, ld);
    model_step(lg);
  endtask

  task automatic idle(input int n);
    bit lg;
    for (int i = 0; i < n; i++) slot(0, 0, '0, 0, '0, '0, 0, '0, '0, lg);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_din"}, 32'(mem_din), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_ula_dout"}, 32'(ula_dout), 0);
    chk({tag, "_ula_valid"}, 32'(ula_valid), 0);
    chk({tag, "_ldr_ack"}, 32'(ldr_ack), 0);
    chk({tag, "_cpu_full"}, 32'(cpu_full), 0);
    chk({tag, "_cpu_ovf"}, 32'(cpu_ovf), 0);
  endtask

  // Monitor: pops expectations when the DUT presents (or should present) an event.
  initial begin
    bit exp;
    forever begin
      @(posedge clk); #1;
      exp = (wq.size() > 0) && (wq[0].e <= edge_n);
      if (mem_we || exp) begin
        if (exp) begin
          chk("write_we", 32'(mem_we), 1);
          chk("write_addr_data", {9'h0, mem_addr, mem_din}, {9'h0, wq[0].a, wq[0].d});
          void'(wq.pop_front());
        end else chk("write_unexpected", 32'(mem_we), 0);
      end
      exp = (aq.size() > 0) && (aq[0] <= edge_n);
      if (ldr_ack || exp) begin
        chk("ldr_ack", 32'(ldr_ack), 32'(exp));
        if (exp) void'(aq.pop_front());
      end
      exp = (uq.size() > 0) && (uq[0].e <= edge_n);
      if (ula_valid || exp) begin
        chk("ula_valid", 32'(ula_valid), 32'(exp));
        if (exp) begin
          chk("ula_dout", 32'(ula_dout), 32'(uq[0].d));
          void'(uq.pop_front());
        end
      end
      chk("cpu_full", 32'(cpu_full), 32'(exp_full));
      chk("cpu_ovf", 32'(cpu_ovf), 32'(exp_ovf));
    end
  end

  initial begin
    bit lg, lr;
    bit ce, rd, wr;
    for (int i = 0; i < 32768; i++) begin
      vram[i]   = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    vram[15'h1800]   = 8'hA5;
    shadow[15'h1800] = 8'hA5;

    #1 nRESET = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    nRESET = 1'b1;
    set_in(0, 0, '0, 0, '0, '0, 0, '0, '0);
    model_step(lg);

    // ULA only: strobe every 4th clock at 0x1800.
    for (int i = 0; i < 16; i++)
      slot((i % 4) == 0, 1, 15'h1800, 0, '0, '0, 0, '0, '0, lg);
    idle(4);

    // Collision: ULA, CPU and loader in one cycle.
    slot(1, 1, 15'h1800, 1, 15'h0000, 8'h3C, 1, 15'h0100, 8'h77, lg);
    lr = !lg;
    for (int i = 0; i < 4 && lr; i++) begin
      slot(0, 0, '0, 0, '0, '0, 1, 15'h0100, 8'h77, lg);
      if (lg) lr = 0;
    end
    idle(4);

    // Fill under ULA slots, then push and pop in the same slot.
    for (int i = 0; i < 4; i++)
      slot(1, 1, 15'(16 + i), 1, 15'(32 + i), 8'(8'h10 + i), 0, '0, '0, lg);
    slot(0, 0, '0, 1, 15'h0040, 8'hEE, 0, '0, '0, lg);
    idle(2 * FIFO_DEPTH + 4);

    // Overflow: 6 writes during 6 consecutive ULA slots.
    for (int i = 0; i < 6; i++)
      slot(1, 1, 15'(64 + i), 1, 15'(80 + i), 8'(8'h60 + i), 0, '0, '0, lg);
    idle(2 * FIFO_DEPTH + 4);

    // Starvation: CPU writes every clock with the loader waiting.
    for (int i = 0; i < 40; i++)
      slot(0, 0, '0, 1, 15'(15'h0200 + i), 8'($urandom), 1,
           15'(15'h0300 + i), 8'($urandom), lg);
    idle(2 * FIFO_DEPTH + 4);

    // Random traffic over a small address window to provoke hazards.
    lr = 0;
    for (int i = 0; i < 400; i++) begin
      if (!lr) lr = ($urandom_range(3) == 0);
      else if ($urandom_range(15) == 0) lr = 0;
      ce = ($urandom_range(2) == 0);
      rd = ($urandom_range(3) != 0);
      wr = ($urandom_range(1) == 1);
      slot(ce, rd, 15'($urandom_range(15)), wr, 15'($urandom_range(15)), 8'($urandom),
           lr, 15'($urandom_range(15)), 8'($urandom), lg);
      if (lg && $urandom_range(1) == 1) lr = 0;
    end
    idle(2 * FIFO_DEPTH + 4);

    // Reset mid-fetch with three FIFO entries pending.
    for (int i = 0; i < 3; i++)
      slot(1, 1, 15'(i), 1, 15'(15'h0500 + i), 8'(8'hC0 + i), 0, '0, '0, lg);
    slot(1, 1, 15'h1800, 0, '0, '0, 0, '0, '0, lg);
    @(posedge clk); #2;
    nRESET = 1'b0;
    model_reset();
    @(negedge clk);
    set_in(0, 0, '0, 0, '0, '0, 0, '0, '0);
    check_zero_outputs("midreset");
    @(negedge clk);
    nRESET = 1'b1;
    set_in(1, 1, 15'h1800, 0, '0, '0, 0, '0, '0);
    model_step(lg);
    for (int i = 0; i < 4; i++)
      slot(1, 1, 15'h1800, 0, '0, '0, 0, '0, '0, lg);
    idle(2 * FIFO_DEPTH + 6);

    chk("writes_drained", 32'(wq.size()), 0);
    chk("acks_drained", 32'(aq.size()), 0);
    chk("fetches_drained", 32'(uq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-RAM arbiter that shares one 32 KB synchronous BRAM between three requesters: the ULA display fetch, the CPU write mirror for screen pages, and the snapshot/tape bulk loader. The ULA fetch has hard priority on pixel-clock slots. CPU mirror writes are buffered in a small FIFO, and the loader uses a req/ack handshake with starvation protection. The block sits between the ULA `vram_addr`/`vram_dout` pair and the physical VRAM port.

## Interface
- `FIFO_DEPTH`, default 4: CPU write FIFO depth. Must be a power of 2 and at least 2.
- `STARVE_LIMIT`, default 8: consecutive CPU grants allowed while the loader waits.
- `clk_sys`  in  1  master clock; all logic runs on its rising edge.
- `nRESET`  in  1  asynchronous, active-low reset.
- `ce_7mn`  in  1  ULA slot strobe.
- `ula_rd`  in  1  ULA fetch request; qualified by `ce_7mn`.
- `ula_addr`  in  15  ULA fetch address.
- `ula_dout`  out  8  last fetched byte; held between fetches.
- `ula_valid`  out  1  one-cycle pulse when `ula_dout` updates.
- `cpu_wr`  in  1  one-cycle CPU mirror write strobe.
- `cpu_addr`  in  15  CPU write address.
- `cpu_data`  in  8  CPU write data.
- `cpu_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `cpu_ovf`  out  1  sticky flag: a CPU write was dropped.
- `ldr_req`  in  1  loader write request (level).
- `ldr_addr`  in  15  loader write address.
- `ldr_data`  in  8  loader write data.
- `ldr_ack`  out  1  one-cycle pulse: the loader write has been issued.
- `mem_addr`  out  15  registered BRAM address.
- `mem_din`  out  8  registered BRAM write data.
- `mem_we`  out  1  registered BRAM write enable.
- `mem_dout`  in  8  BRAM read data; valid one clock after the address edge.

## Operation
- Every `clk_sys` cycle is one arbitration slot. Each slot makes one grant and updates `mem_*` at the edge.
- Priority per slot:
  1. ULA, when `ce_7mn & ula_rd`.
  2. Loader, when `ldr_req` is high and `starve_cnt == STARVE_LIMIT`.
  3. CPU FIFO head, when the FIFO is non-empty.
  4. Loader, when `ldr_req` is high.
  5. Idle: `mem_we` = 0 and `mem_addr` holds its value.
- ULA grant drives `mem_addr = ula_addr` and `mem_we = 0`. A fetch-tracking pipe bit is set; two edges later `ula_dout <= mem_dout` and `ula_valid` pulses.
- CPU grant drives `mem_addr`, `mem_din` and `mem_we = 1` from the FIFO head, then pops the head.
- Loader grant drives `mem_addr`, `mem_din` and `mem_we = 1` from the `ldr_*` inputs, and pulses `ldr_ack` in the same edge.
- FIFO push:
  - Accepted when `cpu_wr` is high and either the FIFO is not full or a pop happens in the same slot.
  - Otherwise the write is dropped and `cpu_ovf` is set. `cpu_ovf` clears only on reset.
  - Push and pop in the same slot leave the count unchanged.
  - Pointers are log2(`FIFO_DEPTH`) bits wide and wrap modulo the depth.
- `starve_cnt` (width ceil(log2(`STARVE_LIMIT`+1))):
  - Increments on each CPU grant while `ldr_req` is high.
  - Clears on a loader grant or whenever `ldr_req` is low.
  - Saturates at `STARVE_LIMIT`.
  - ULA grants leave it unchanged.
- Loader protocol:
  - After `ldr_ack`, the loader must present the next `ldr_addr`/`ldr_data` before the following edge, or drop `ldr_req`.
  - `ldr_req` may fall at any time; no grant is issued while it is low.
- Same-address hazard: a CPU write and a ULA read to the same address in adjacent slots are not forwarded. The ULA sees the memory content at its own grant edge.

## Timing
- Reset (`nRESET` low, asynchronous) forces all of the following to 0: `mem_addr`, `mem_din`, `mem_we`, `ula_dout`, `ula_valid`, `ldr_ack`, `cpu_full`, `cpu_ovf`, the FIFO pointers and count, `starve_cnt`, and the fetch pipe.
- Reset mid-operation discards FIFO contents and any in-flight ULA fetch; no `ula_valid` follows.
- Deassertion of `nRESET` is synchronised internally, so the first grant occurs on the second edge after release.
- ULA latency: request sampled at edge E0, `mem_addr` valid after E0, BRAM read at E1, `ula_dout`/`ula_valid` at E2. Fixed at 2 clocks and independent of the other requesters.
- Back-to-back ULA fetches on consecutive `ce_7mn` strobes are supported at full rate.
- CPU write latency: at least 1 clock from push to `mem_we`, and at most 1 + 2·`FIFO_DEPTH` clocks with no ULA slots.
- `cpu_full` is registered and reflects the count after the current edge.
- Worst-case loader wait with a continuous CPU stream: `STARVE_LIMIT` CPU grants, plus any interleaved ULA slots, then 1 loader slot.

## Test plan
- ULA only: `ce_7mn` every 4th clock, `ula_addr` = 0x1800 preloaded with 0xA5 -> `mem_we` = 0, `ula_dout` = 0xA5 with `ula_valid` exactly 2 clocks after the strobe edge.
- Collision: `ula_rd` strobe, `cpu_wr` (0x0000←0x3C) and `ldr_req` all in one cycle -> slot 0 ULA, slot 1 CPU write 0x3C, slot 2 loader with `ldr_ack`; no write lost.
- FIFO overflow, depth 4: 6 `cpu_wr` pulses during 6 consecutive ULA slots -> `cpu_full` = 1 after the 4th, writes 5–6 dropped, `cpu_ovf` = 1, then exactly 4 writes drain in order.
- Starvation: continuous `cpu_wr` every clock with `ldr_req` high and `STARVE_LIMIT` = 8 -> `ldr_ack` once every 9 non-ULA slots; `starve_cnt` never exceeds 8.
- Full push+pop: FIFO full, a CPU grant and `cpu_wr` in the same slot -> push accepted, count stays 4, `cpu_ovf` stays 0.
- Reset mid-fetch: `nRESET` low 1 clock after a ULA grant with 3 FIFO entries -> no `ula_valid`, all outputs 0, FIFO empty; first grant occurs on the second edge after release.
